acq_multi_channel: RTL and testbench
====================================

ACQ_MULTI_CHANNEL -- requirements
Module: acq_multi_channel

Interface
REQ-001 Parameters SHALL be: N_CH, default 4, number of input channels; SAMPLE_W, default 7, bits per sample; DEPTH, default 8, entries per bank (power of 2, >=2); TS_W, default 8, timestamp bits.
REQ-002 Derived: CH_ID_W = max(1, clog2(N_CH)); word width W = TS_W+CH_ID_W+SAMPLE_W (ACQ_TIMESTAMP_EN defined) or CH_ID_W+SAMPLE_W (undefined).
REQ-003 input_acquisition_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ch_data  in  N_CH*SAMPLE_W  unsigned samples; channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-006 sample_valid  in  1  ch_data valid this cycle.
REQ-007 threshold  in  SAMPLE_W  unsigned detection level.
REQ-008 shift_en  in  1  serial readout strobe; one bit advances per high cycle.
REQ-009 serial_out  out  1  registered serial data, MSB first.
REQ-010 frame_sync  out  1  high while serial_out carries bit W-1 of a word.
REQ-011 signal_detected  out  1  one-cycle pulse per accepted hit.
REQ-012 memorization_completed  out  1  one-cycle pulse on bank swap.
REQ-013 sending_data  out  1  high while read side is sending.
REQ-014 write_bank, read_bank  out  1 each  bank currently written / read; always complementary.
REQ-015 overflow  out  1  sticky: a hit was dropped.
REQ-016 state_reg_FSM  out  3  write FSM state: 0 IDLE, 1 RECORD, 2 WAIT, 3 SWAP.

Function
REQ-017 Hit: sample_valid=1 and any channel strictly > threshold; hit channel = lowest index above threshold.
REQ-018 Timestamp: free-running TS_W counter, +1 every cycle, wraps to 0; entry captures value of the hit cycle.
REQ-019 Entry = {timestamp (if enabled), hit channel id, hit channel sample}, MSB to LSB.
REQ-020 IDLE: first hit writes entry 0 of write_bank, goes to RECORD; write pointer = 1.
REQ-021 RECORD: each hit writes at pointer, pointer+1; hit that writes entry DEPTH-1 moves to SWAP next cycle.
REQ-022 signal_detected SHALL pulse the cycle after each hit written (IDLE or RECORD); not for dropped hits.
REQ-023 SWAP (1 cycle): if read side idle -> toggle both bank bits, pulse memorization_completed same cycle, start read side, return to IDLE, pointer=0; else go to WAIT.
REQ-024 WAIT: hits dropped, each sets overflow; on read side idle -> SWAP behaviour next cycle.
REQ-025 SWAP/WAIT hits SHALL be dropped and set overflow.
REQ-026 Read side: sends DEPTH words of read_bank, entry 0 first, MSB first; one bit per shift_en cycle; sending_data high from swap cycle until the last bit's shift_en cycle, low next cycle.
REQ-027 serial_out/frame_sync SHALL present the current bit from the cycle after swap; shift_en=0 holds outputs.
REQ-028 Idle read side: serial_out=0, frame_sync=0.
REQ-029 Hit and read completion in same cycle: both processed; completion visible to WAIT next cycle.

Reset
REQ-030 reset=1 at any edge, including mid-record or mid-send: FSM IDLE, pointer 0, timestamp 0, write_bank=0, read_bank=1, sending_data=0, serial_out=0, frame_sync=0, signal_detected=0, memorization_completed=0, overflow=0, state_reg_FSM=0; in-flight data discarded.
REQ-031 Memory contents SHALL NOT require reset.

Configuration
REQ-032 Macro ACQ_TIMESTAMP_EN: defined -> timestamp counter present, field included, W includes TS_W; undefined -> no counter, words are {ch id, sample}, all else identical.

Verification (N_CH=4, SAMPLE_W=7, DEPTH=8, TS_W=8, threshold=50, macro defined)
REQ-033 Reset, then ch_data all 10 with sample_valid -> no signal_detected, state 0, overflow 0.
REQ-034 Channel 2=60, channel 3=70 at timestamp 5 -> entry {5, 2, 60}; signal_detected pulse next cycle; state 1.
REQ-035 8 hits, shift_en held 1 -> state 3 then 0, memorization_completed pulse, write_bank 1, read_bank 0; 8x17 bits out, frame_sync every 17 bits.
REQ-036 8 more hits during send with shift_en=0 -> state 2, ninth hit sets overflow; after send done, swap occurs.
REQ-037 Reset asserted mid-send (bit 30) -> next cycle all REQ-030 values; timestamp restarts at 0.
REQ-038 Macro undefined, repeat REQ-034 -> word {2, 60}, 9 bits.

Source files
------------

// File: rtl/acq_multi_channel.sv
// +--------------------------------------------------------------------------+
// | acq_multi_channel: multi-channel threshold hit recorder with ping-pong   |
// | banks and MSB-first serial readout. Optional macro: ACQ_TIMESTAMP_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module acq_multi_channel #(
  parameter int N_CH     = 4,
  parameter int SAMPLE_W = 7,
  parameter int DEPTH    = 8,
  parameter int TS_W     = 8
) (
  input  logic                     input_acquisition_clk,
  input  logic                     reset,
  input  logic [N_CH*SAMPLE_W-1:0] ch_data,
  input  logic                     sample_valid,
  input  logic [SAMPLE_W-1:0]      threshold,
  input  logic                     shift_en,
  output logic                     serial_out,
  output logic                     frame_sync,
  output logic                     signal_detected,
  output logic                     memorization_completed,
  output logic                     sending_data,
  output logic                     write_bank,
  output logic                     read_bank,
  output logic                     overflow,
  output logic [2:0]               state_reg_FSM
);

  localparam int CH_ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
`ifdef ACQ_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int W     = TS_EN * TS_W + CH_ID_W + SAMPLE_W;
  localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECORD = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SWAP   = 3'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_wbank, r_sd, r_ovf;
  logic               r_read_active, r_serial, r_fs;
  logic [PTR_W-1:0]   r_word;
  logic [BIT_W-1:0]   r_bit;
  logic [W-1:0]       r_mem [2*DEPTH];

  logic               w_hit, w_wr_en, w_swap, w_drop, w_last_bit;
  logic [CH_ID_W-1:0] w_hit_ch;
  logic [SAMPLE_W-1:0] w_hit_smp;
  logic [W-1:0]       w_entry, w_rd_word;
  logic [PTR_W-1:0]   w_next_word;
  logic [BIT_W-1:0]   w_next_bit, w_rd_bit;
  logic [PTR_W:0]     w_rd_addr;

  // Scan from the top so the lowest channel above threshold wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ch  = '0;
    w_hit_smp = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (sample_valid && (ch_data[k*SAMPLE_W +: SAMPLE_W] > threshold)) begin
        w_hit     = 1'b1;
        w_hit_ch  = CH_ID_W'(k);
        w_hit_smp = ch_data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

`ifdef ACQ_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  always_ff @(posedge input_acquisition_clk) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end
  assign w_entry = {r_ts, w_hit_ch, w_hit_smp};
`else
  assign w_entry = {w_hit_ch, w_hit_smp};
`endif

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_wr_en     = 1'b1;
          w_state_nxt = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (w_hit) begin
          w_wr_en = 1'b1;
          if (r_ptr == PTR_W'(DEPTH - 1)) w_state_nxt = ST_SWAP;
        end
      end
      ST_SWAP: begin
        w_drop = w_hit;
        if (!r_read_active) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_drop = w_hit;
        if (!r_read_active) w_state_nxt = ST_SWAP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_wbank <= 1'b0;
      r_sd    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_sd <= w_wr_en;
      if (w_wr_en) r_ptr <= r_ptr + 1'b1;
      if (w_swap) begin
        r_wbank <= ~r_wbank;
        r_ptr   <= '0;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge input_acquisition_clk) begin
    if (w_wr_en) r_mem[{r_wbank, r_ptr}] <= w_entry;
  end

  always_comb begin
    w_last_bit = (r_word == PTR_W'(DEPTH - 1)) && (r_bit == '0);
    if (r_bit == '0) begin
      w_next_bit  = BIT_W'(W - 1);
      w_next_word = r_word + 1'b1;
    end else begin
      w_next_bit  = r_bit - 1'b1;
      w_next_word = r_word;
    end
    // On a swap the bank being filled becomes the read bank at the same edge.
    if (w_swap) begin
      w_rd_addr = {r_wbank, PTR_W'(0)};
      w_rd_bit  = BIT_W'(W - 1);
    end else begin
      w_rd_addr = {~r_wbank, w_next_word};
      w_rd_bit  = w_next_bit;
    end
  end

  assign w_rd_word = r_mem[w_rd_addr];

  always_ff @(posedge input_acquisition_clk) begin
    if (reset) begin
      r_read_active <= 1'b0;
      r_serial      <= 1'b0;
      r_fs          <= 1'b0;
      r_word        <= '0;
      r_bit         <= '0;
    end else if (w_swap) begin
      r_read_active <= 1'b1;
      r_word        <= '0;
      r_bit         <= BIT_W'(W - 1);
      r_serial      <= w_rd_word[w_rd_bit];
      r_fs          <= 1'b1;
    end else if (r_read_active && shift_en) begin
      if (w_last_bit) begin
        r_read_active <= 1'b0;
        r_serial      <= 1'b0;
        r_fs          <= 1'b0;
      end else begin
        r_word   <= w_next_word;
        r_bit    <= w_next_bit;
        r_serial <= w_rd_word[w_rd_bit];
        r_fs     <= (w_next_bit == BIT_W'(W - 1));
      end
    end
  end

  assign serial_out             = r_serial;
  assign frame_sync             = r_fs;
  assign signal_detected        = r_sd;
  assign memorization_completed = w_swap;
  assign sending_data           = r_read_active | w_swap;
  assign write_bank             = r_wbank;
  assign read_bank              = ~r_wbank;
  assign overflow               = r_ovf;
  assign state_reg_FSM          = r_state;

endmodule

`default_nettype wire

// File: tb/tb_acq_multi_channel.sv
// +--------------------------------------------------------------------------+
// | tb_acq_multi_channel: vector table, corner sequences and random traffic  |
// | against a queue-based reference model. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_acq_multi_channel;

  localparam int N_CH     = 4;
  localparam int SAMPLE_W = 7;
  localparam int DEPTH    = 8;
  localparam int TS_W     = 8;
  localparam int CH_ID_W  = 2;
`ifdef ACQ_TIMESTAMP_EN
  localparam int W = TS_W + CH_ID_W + SAMPLE_W;
`else
  localparam int W = CH_ID_W + SAMPLE_W;
`endif

  typedef logic [W-1:0] word_t;

  typedef struct packed {
    logic [6:0] c0, c1, c2, c3;
    logic       valid;
    logic [6:0] thr;
    logic       hit;
    logic [1:0] ch;
    logic [6:0] smp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic [N_CH*SAMPLE_W-1:0] ch_data;
  logic                     sample_valid;
  logic [SAMPLE_W-1:0]      threshold;
  logic                     shift_en;
  logic serial_out, frame_sync, signal_detected, memorization_completed;
  logic sending_data, write_bank, read_bank, overflow;
  logic [2:0] state_reg_FSM;

  acq_multi_channel #(.N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .input_acquisition_clk (clk),
    .reset                 (reset),
    .ch_data               (ch_data),
    .sample_valid          (sample_valid),
    .threshold             (threshold),
    .shift_en              (shift_en),
    .serial_out            (serial_out),
    .frame_sync            (frame_sync),
    .signal_detected       (signal_detected),
    .memorization_completed(memorization_completed),
    .sending_data          (sending_data),
    .write_bank            (write_bank),
    .read_bank             (read_bank),
    .overflow              (overflow),
    .state_reg_FSM         (state_reg_FSM)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: entries of the bank being filled, bits still to send.
  word_t m_entries[$];
  bit    m_bits[$];
  int    m_phase;   // 0 collecting, 1 bank full, 2 waiting for reader
  int    m_ts;
  bit    m_wb, m_ovf, m_sd;
  int    tcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit    hit;
    bit    busy;
    int    hch, hsmp;
    word_t e;
    if (reset) begin
      m_entries.delete();
      m_bits.delete();
      m_phase = 0;
      m_ts    = 0;
      m_wb    = 1'b0;
      m_ovf   = 1'b0;
      m_sd    = 1'b0;
      return;
    end
    hit = 1'b0; hch = 0; hsmp = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (!hit && sample_valid && (ch_data[k*SAMPLE_W +: SAMPLE_W] > threshold)) begin
        hit  = 1'b1;
        hch  = k;
        hsmp = int'(ch_data[k*SAMPLE_W +: SAMPLE_W]);
      end
    end
    e = word_t'({CH_ID_W'(hch), SAMPLE_W'(hsmp)});
`ifdef ACQ_TIMESTAMP_EN
    e[W-1 -: TS_W] = TS_W'(m_ts);
`endif
    busy = (m_bits.size() > 0);
    m_sd = 1'b0;
    if (busy && shift_en) void'(m_bits.pop_front());
    case (m_phase)
      0: if (hit) begin
        m_entries.push_back(e);
        m_sd = 1'b1;
        if (m_entries.size() == DEPTH) m_phase = 1;
      end
      1: begin
        if (hit) m_ovf = 1'b1;
        if (!busy) begin
          m_wb = ~m_wb;
          foreach (m_entries[i])
            for (int b = W - 1; b >= 0; b--) m_bits.push_back(m_entries[i][b]);
          m_entries.delete();
          m_phase = 0;
        end else begin
          m_phase = 2;
        end
      end
      default: begin
        if (hit) m_ovf = 1'b1;
        if (!busy) m_phase = 1;
      end
    endcase
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_cycle();
    logic [10:0] act, exp;
    bit has;
    int st;
    has = (m_bits.size() > 0);
    st  = (m_phase == 0) ? ((m_entries.size() > 0) ? 1 : 0) : ((m_phase == 1) ? 3 : 2);
    exp = {has ? m_bits[0] : 1'b0, has && ((m_bits.size() % W) == 0), m_sd,
           (m_phase == 1) && !has, has || (m_phase == 1), m_wb, ~m_wb, m_ovf, 3'(st)};
    act = {serial_out, frame_sync, signal_detected, memorization_completed, sending_data,
           write_bank, read_bank, overflow, state_reg_FSM};
    check("cycle_outputs", 64'(act), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    tcnt = reset ? 0 : tcnt + 1;
    @(negedge clk);
    check_cycle();
  endtask

  vec_t       tbl [15];
  int         hit_ts[$];
  logic [1:0] hit_ch[$];
  logic [6:0] hit_smp[$];
  bit         rx[$];
  word_t      got, want;
  bit         found;

  initial begin
    reset = 1'b1; ch_data = '0; sample_valid = 1'b0; threshold = 7'd50; shift_en = 1'b0;
    tcnt = 0;
    tbl[0]  = '{7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 7'd50,  1'b0, 2'd0, 7'd0};
    tbl[1]  = '{7'd10, 7'd10, 7'd10, 7'd10, 1'b1, 7'd50,  1'b0, 2'd0, 7'd0};
    tbl[2]  = '{7'd60, 7'd70, 7'd80, 7'd90, 1'b0, 7'd50,  1'b0, 2'd0, 7'd0};
    tbl[3]  = '{7'd50, 7'd50, 7'd50, 7'd50, 1'b1, 7'd50,  1'b0, 2'd0, 7'd0};
    tbl[4]  = '{7'd0,  7'd0,  7'd100,7'd0,  1'b1, 7'd127, 1'b0, 2'd0, 7'd0};
    tbl[5]  = '{7'd10, 7'd10, 7'd60, 7'd70, 1'b1, 7'd50,  1'b1, 2'd2, 7'd60};
    tbl[6]  = '{7'd51, 7'd0,  7'd0,  7'd0,  1'b1, 7'd50,  1'b1, 2'd0, 7'd51};
    tbl[7]  = '{7'd0,  7'd0,  7'd0,  7'd127,1'b1, 7'd50,  1'b1, 2'd3, 7'd127};
    tbl[8]  = '{7'd127,7'd127,7'd127,7'd127,1'b1, 7'd126, 1'b1, 2'd0, 7'd127};
    tbl[9]  = '{7'd0,  7'd5,  7'd0,  7'd0,  1'b1, 7'd0,   1'b1, 2'd1, 7'd5};
    tbl[10] = '{7'd0,  7'd0,  7'd0,  7'd0,  1'b1, 7'd0,   1'b0, 2'd0, 7'd0};
    tbl[11] = '{7'd90, 7'd80, 7'd0,  7'd0,  1'b1, 7'd50,  1'b1, 2'd0, 7'd90};
    tbl[12] = '{7'd0,  7'd60, 7'd60, 7'd60, 1'b1, 7'd50,  1'b1, 2'd1, 7'd60};
    tbl[13] = '{7'd127,7'd127,7'd127,7'd127,1'b0, 7'd0,   1'b0, 2'd0, 7'd0};
    tbl[14] = '{7'd1,  7'd2,  7'd3,  7'd4,  1'b1, 7'd3,   1'b1, 2'd3, 7'd4};

    tick();
    tick();
    reset    = 1'b0;
    shift_en = 1'b1;

    for (int i = 0; i < 15; i++) begin
      ch_data      = {tbl[i].c3, tbl[i].c2, tbl[i].c1, tbl[i].c0};
      sample_valid = tbl[i].valid;
      threshold    = tbl[i].thr;
      if (tbl[i].hit) begin
        hit_ts.push_back(tcnt);
        hit_ch.push_back(tbl[i].ch);
        hit_smp.push_back(tbl[i].smp);
      end
      tick();
      check($sformatf("sig_det_vec%0d", i), 64'(signal_detected), 64'(tbl[i].hit));
      if (i == 5) check("state_after_first_hit", 64'(state_reg_FSM), 64'd1);
    end
    sample_valid = 1'b0;
    check("state_full", 64'(state_reg_FSM), 64'd3);
    check("mem_done_pulse", 64'(memorization_completed), 64'd1);
    tick();
    check("banks_after_swap", 64'({write_bank, read_bank, state_reg_FSM}), 64'b10_000);

    for (int i = 0; i < 5; i++) begin
      rx.push_back(serial_out);
      tick();
    end

    shift_en  = 1'b0;
    ch_data   = {7'd0, 7'd0, 7'd99, 7'd0};
    threshold = 7'd50;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("ovf_before_drop", 64'(overflow), 64'd0);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("state_wait", 64'(state_reg_FSM), 64'd2);
    check("ovf_after_drop", 64'(overflow), 64'd1);
    check("no_sig_on_drop", 64'(signal_detected), 64'd0);

    shift_en = 1'b1;
    for (int i = 0; i < DEPTH * W + 10 && m_bits.size() > 0; i++) begin
      rx.push_back(serial_out);
      tick();
    end
    check("rx_bit_count", 64'(rx.size()), 64'(DEPTH * W));
    for (int j = 0; j < DEPTH; j++) begin
      got = '0;
      for (int b = 0; b < W; b++) got = {got[W-2:0], rx[j*W + b]};
      want = word_t'({hit_ch[j], hit_smp[j]});
`ifdef ACQ_TIMESTAMP_EN
      want[W-1 -: TS_W] = TS_W'(hit_ts[j]);
`endif
      check($sformatf("word%0d_ts%0d", j, hit_ts[j]), 64'(got), 64'(want));
    end

    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (memorization_completed) found = 1'b1;
      else tick();
    end
    check("swap_after_wait", 64'(found), 64'd1);
    tick();
    check("write_bank_back", 64'(write_bank), 64'd0);

    for (int i = 0; i < 30; i++) tick();
    reset = 1'b1;
    tick();
    check("reset_mid_send", 64'({serial_out, frame_sync, signal_detected, memorization_completed,
          sending_data, write_bank, read_bank, overflow, state_reg_FSM}), 64'b00000010000);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 1499) == 0);
      sample_valid = ($urandom_range(0, 2) == 0);
      ch_data      = (N_CH*SAMPLE_W)'($urandom);
      threshold    = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(80, 127));
      shift_en     = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
